// File: rtl/multirate_step_gen.sv
// Multi-rate square-wave divider bank with a selectable tick and an up/down step counter.
// Each channel free-runs; the one-hot select routes one channel's terminal count to the step logic.

module step_gen_div #(
    parameter int              CNT_W = 26,
    parameter logic [CNT_W-1:0] HALF = '0
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_clk,
    output logic o_term
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             w_term;

    assign w_term = (r_cnt == HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (w_term) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_clk  = r_clk;
    assign o_term = w_term;

endmodule

module multirate_step_gen #(
    parameter longint              SYS_CLK_HZ = 100_000_000,
    parameter int                  NCH        = 4,
    parameter logic [NCH*32-1:0]   RATE_HZ    = {32'd190, 32'd48, 32'd12, 32'd1},
    parameter int                  CNT_W      = 26,
    parameter int                  STEP_MAX   = 20,
    parameter int                  STEP_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    sel,
    input  logic              run,
    input  logic              up,
    input  logic              clr,
    output logic [NCH-1:0]    clk_out,
    output logic              tick,
    output logic [STEP_W-1:0] step,
    output logic              wrap,
    output logic              sel_err
);

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("multirate_step_gen: NCH must be 1..8");
    end

    logic [NCH-1:0] w_term_vec;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam longint RATE   = longint'(RATE_HZ[gi*32 +: 32]);
        // Zero rate is folded into an out-of-range HALF rather than dividing by zero.
        localparam longint HALF_L = (RATE == 0) ? -64'sd1
                                  : SYS_CLK_HZ / (2 * RATE + longint'(RATE == 0)) - 1;
        if (HALF_L < 0 || HALF_L >= (longint'(1) << CNT_W)) begin : g_bad_half
            $error("multirate_step_gen: channel half-period does not fit CNT_W");
        end
        step_gen_div #(
            .CNT_W (CNT_W),
            .HALF  (HALF_L[CNT_W-1:0])
        ) u_div (
            .clk    (clk),
            .rst_n  (rst_n),
            .o_clk  (clk_out[gi]),
            .o_term (w_term_vec[gi])
        );
    end

    logic w_onehot;
    logic w_term;

    assign w_onehot = (sel != '0) && ((sel & (sel - NCH'(1))) == '0);
    assign w_term   = w_onehot && |(sel & w_term_vec);

    logic [STEP_W-1:0] r_step;
    logic              r_tick;
    logic              r_wrap;
    logic              r_sel_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step    <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_tick    <= w_term;
            r_sel_err <= ~w_onehot;
            r_wrap    <= 1'b0;
            // Clear wins over a coincident tick; wrap only pulses on a boundary crossing.
            if (clr) begin
                r_step <= '0;
            end else if (w_term && run) begin
                if (up) begin
                    if (r_step == STEP_W'(STEP_MAX)) begin
                        r_step <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end else begin
                    if (r_step == '0) begin
                        r_step <= STEP_W'(STEP_MAX);
                        r_wrap <= 1'b1;
                    end else begin
                        r_step <= r_step - 1'b1;
                    end
                end
            end
        end
    end

    assign tick    = r_tick;
    assign step    = r_step;
    assign wrap    = r_wrap;
    assign sel_err = r_sel_err;

endmodule
